// File: rtl/mmp_pkg.sv
// Shared definitions for the strobe-capture block: edge-select encodings and
// the per-cycle FIFO operation bundle.
package mmp_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef struct packed {
    logic wr;   // entry written at tail
    logic rd;   // head entry consumed
    logic ovf;  // push dropped because the FIFO was full
  } fifo_op_t;

  function automatic logic edge_hit(input int sel, input logic rise, input logic fall);
    case (sel)
      EDGE_RISE: edge_hit = rise;
      EDGE_FALL: edge_hit = fall;
      default:   edge_hit = rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/mmp_strobe_qual.sv
// Synchronises a foreign strobe and emits a one-cycle push once the level has
// been stable for STABLE cycles on both sides of an accepted edge.
module mmp_strobe_qual
  import mmp_pkg::*;
#(
  parameter int STABLE = 3,
  parameter int EDGE   = EDGE_RISE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strb,
  output logic push
);

  localparam int HW = 2 * STABLE;
  // Older samples live in the MSBs, so a clean rise reads as 0..01..1.
  localparam logic [HW-1:0] RISE_PAT = {{STABLE{1'b0}}, {STABLE{1'b1}}};

  logic [1:0]    sync;
  logic [HW-1:0] hist;
  logic          rise;
  logic          fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= '0;
    end else begin
      sync <= {sync[0], strb};
      hist <= {hist[HW-2:0], sync[1]};
    end
  end

  // The pattern shifts out on the next cycle, so each edge qualifies once.
  assign rise = (hist == RISE_PAT);
  assign fall = (hist == ~RISE_PAT);
  assign push = edge_hit(EDGE, rise, fall);

endmodule

// File: rtl/mmp_strobe_capture.sv
// Captures CH signed channel words on each qualified strobe edge into a
// show-ahead FIFO with sticky overflow reporting.
module mmp_strobe_capture
  import mmp_pkg::*;
#(
  parameter int CH     = 2,
  parameter int W      = 16,
  parameter int DEPTH  = 4,
  parameter int STABLE = 3,
  parameter int EDGE   = EDGE_RISE
) (
  input  logic                       i_CLK,
  input  logic                       i_RST_n,
  input  logic                       i_STRB,
  input  logic [CH*W-1:0]            i_DATA,
  output logic                       o_VALID,
  input  logic                       i_READY,
  output logic [CH*W-1:0]            o_DATA,
  output logic [$clog2(DEPTH):0]     o_LEVEL,
  output logic                       o_OVF,
  input  logic                       i_OVF_CLR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef logic [CH-1:0][W-1:0] entry_t;

  entry_t         mem [DEPTH];
  entry_t         din;
  entry_t         head_q;
  entry_t         head_next;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  rd_next;
  logic [LW-1:0]  level;
  logic [LW-1:0]  lvl_next;
  logic           push_req;
  logic           pop;
  logic           full;
  fifo_op_t       op;

  mmp_strobe_qual #(
    .STABLE (STABLE),
    .EDGE   (EDGE)
  ) u_qual (
    .clk   (i_CLK),
    .rst_n (i_RST_n),
    .strb  (i_STRB),
    .push  (push_req)
  );

  assign din  = i_DATA;
  assign full = (level == FULL_LVL);
  assign pop  = o_VALID && i_READY;

  always_comb begin
    op.wr  = push_req && (!full || pop);
    op.rd  = pop;
    op.ovf = push_req && full && !pop;
    rd_next = op.rd ? rd_ptr + AW'(1) : rd_ptr;
    case ({op.wr, op.rd})
      2'b10:   lvl_next = level + LW'(1);
      2'b01:   lvl_next = level - LW'(1);
      default: lvl_next = level;
    endcase
    // Head is registered so o_DATA stays defined while empty; bypass the
    // write when the entry being written becomes the new head.
    head_next = head_q;
    if (lvl_next != '0)
      head_next = (op.wr && (wr_ptr == rd_next)) ? din : mem[rd_next];
  end

  always_ff @(posedge i_CLK) begin
    if (op.wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head_q <= '0;
      o_OVF  <= 1'b0;
    end else begin
      if (op.wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      level  <= lvl_next;
      head_q <= head_next;
      if (op.ovf)         o_OVF <= 1'b1;
      else if (i_OVF_CLR) o_OVF <= 1'b0;
    end
  end

  assign o_VALID = (level != '0);
  assign o_DATA  = head_q;
  assign o_LEVEL = level;

endmodule

// File: tb/tb_mmp_strobe_capture.sv
// Scoreboard bench: one rising-edge instance and one both-edge instance share
// clock and reset; expected captures are queued when strobes are driven.
module tb_mmp_strobe_capture;

  localparam int CH = 2, W = 16, DEPTH = 4, STABLE = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              strb_a, strb_b;
  logic [CH*W-1:0]   data_a, data_b;
  logic              ready_a, ready_b;
  logic              ovf_clr;
  logic              valid_a, valid_b;
  logic [CH*W-1:0]   dout_a, dout_b;
  logic [2:0]        level_a, level_b;
  logic              ovf_a, ovf_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  always #5 clk = ~clk;

  mmp_strobe_capture #(.CH(CH), .W(W), .DEPTH(DEPTH), .STABLE(STABLE), .EDGE(0)) dut (
    .i_CLK(clk), .i_RST_n(rst_n), .i_STRB(strb_a), .i_DATA(data_a),
    .o_VALID(valid_a), .i_READY(ready_a), .o_DATA(dout_a), .o_LEVEL(level_a),
    .o_OVF(ovf_a), .i_OVF_CLR(ovf_clr)
  );

  mmp_strobe_capture #(.CH(CH), .W(W), .DEPTH(DEPTH), .STABLE(STABLE), .EDGE(2)) dut_b (
    .i_CLK(clk), .i_RST_n(rst_n), .i_STRB(strb_b), .i_DATA(data_b),
    .o_VALID(valid_b), .i_READY(ready_b), .o_DATA(dout_b), .o_LEVEL(level_b),
    .o_OVF(ovf_b), .i_OVF_CLR(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full strobe period on the rising-edge instance; model drops when full.
  task automatic rise_fall_a(input logic [31:0] d);
    data_a = d;
    strb_a = 1'b1;
    if (q_a.size() < DEPTH) q_a.push_back(d);
    tick(8);
    strb_a = 1'b0;
    tick(8);
  endtask

  task automatic pop_a(input string tag);
    logic [31:0] e;
    e = (q_a.size() > 0) ? q_a.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_valid"}, 64'(valid_a), 64'd1);
    chk({tag, "_data"}, 64'(dout_a), 64'(e));
    ready_a = 1'b1;
    tick(1);
    ready_a = 1'b0;
  endtask

  task automatic pop_b(input string tag);
    logic [31:0] e;
    e = (q_b.size() > 0) ? q_b.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_valid"}, 64'(valid_b), 64'd1);
    chk({tag, "_data"}, 64'(dout_b), 64'(e));
    ready_b = 1'b1;
    tick(1);
    ready_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; strb_a = 0; strb_b = 0; data_a = '0; data_b = '0;
    ready_a = 0; ready_b = 0; ovf_clr = 0;
    tick(2);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_level", 64'(level_a), 64'd0);
    chk("rst_ovf",   64'(ovf_a),   64'd0);
    chk("rst_data",  64'(dout_a),  64'd0);
    rst_n = 1'b1;
    tick(4);

    // Single rising edge: valid shows on the 6th falling edge after the drive.
    data_a = 32'h1234_ABCD;
    strb_a = 1'b1;
    q_a.push_back(data_a);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid_a) begin lat = i; break; end
    end
    chk("t1_latency", 64'(lat), 64'(STABLE + 3));
    chk("t1_level", 64'(level_a), 64'd1);
    tick(6);
    chk("t1_single_push", 64'(level_a), 64'd1);
    pop_a("t1_pop");
    strb_a = 1'b0;
    tick(8);
    chk("t1_fall_ignored", 64'(level_a), 64'd0);

    // Glitch shorter than STABLE.
    strb_a = 1'b1; tick(2); strb_a = 1'b0;
    tick(10);
    chk("t2_glitch_level", 64'(level_a), 64'd0);
    chk("t2_glitch_valid", 64'(valid_a), 64'd0);

    // Overflow with no consumer.
    for (int d = 1; d <= 5; d++) rise_fall_a(32'(d));
    chk("t3_level", 64'(level_a), 64'd4);
    chk("t3_ovf", 64'(ovf_a), 64'd1);
    for (int i = 0; i < 4; i++) pop_a("t3_drain");
    chk("t3_empty", 64'(level_a), 64'd0);
    chk("t3_ovf_sticky", 64'(ovf_a), 64'd1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    chk("t3_ovf_clr", 64'(ovf_a), 64'd0);

    // Full with simultaneous pop on the push edge.
    for (int d = 11; d <= 14; d++) rise_fall_a(32'(d));
    data_a = 32'd15;
    strb_a = 1'b1;
    tick(5);
    chk("t4_head_valid", 64'(valid_a), 64'd1);
    chk("t4_head_data", 64'(dout_a), 64'(q_a.pop_front()));
    q_a.push_back(32'd15);
    ready_a = 1'b1; tick(1); ready_a = 1'b0;
    chk("t4_level", 64'(level_a), 64'd4);
    chk("t4_ovf", 64'(ovf_a), 64'd0);
    tick(3); strb_a = 1'b0; tick(8);
    for (int i = 0; i < 4; i++) pop_a("t4_drain");
    chk("t4_empty", 64'(level_a), 64'd0);

    // Clear and overflow in the same cycle: set wins.
    for (int d = 21; d <= 24; d++) rise_fall_a(32'(d));
    data_a = 32'd25;
    strb_a = 1'b1;
    tick(5);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    chk("prio_ovf", 64'(ovf_a), 64'd1);
    chk("prio_level", 64'(level_a), 64'd4);
    tick(3); strb_a = 1'b0; tick(8);
    pop_a("prio_pop");
    chk("pre_rst_level", 64'(level_a), 64'd3);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(valid_a), 64'd0);
    chk("t6_level", 64'(level_a), 64'd0);
    chk("t6_ovf",   64'(ovf_a),   64'd0);
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);

    // Both edges on the second instance.
    data_b = 32'hAAAA_5555; strb_b = 1'b1; q_b.push_back(data_b); tick(8);
    data_b = 32'h0F0F_F0F0; strb_b = 1'b0; q_b.push_back(data_b); tick(8);
    chk("t5_level", 64'(level_b), 64'd2);
    pop_b("t5_pop0");
    pop_b("t5_pop1");
    chk("t5_empty", 64'(level_b), 64'd0);
    chk("t5_ovf", 64'(ovf_b), 64'd0);

    // Strobe already high at reset release yields one rising capture.
    rst_n = 1'b0; strb_a = 1'b1; data_a = 32'h0000_0055;
    tick(2);
    rst_n = 1'b1;
    q_a.push_back(data_a);
    tick(10);
    chk("rel_high_level", 64'(level_a), 64'd1);
    pop_a("rel_high_pop");
    chk("sb_drained", 64'(q_a.size() + q_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmp_strobe_capture.md
MMP_STROBE_CAPTURE -- requirements
Module: mmp_strobe_capture

Interface
REQ-001 Parameter CH, default 2: number of sample channels captured per strobe.
REQ-002 Parameter W, default 16: width of each channel, in bits, signed.
REQ-003 Parameter DEPTH, default 4: number of capture FIFO entries; power of two, 2..64.
REQ-004 Parameter STABLE, default 3: number of consecutive equal samples required on each side of a strobe edge.
REQ-005 Parameter EDGE, default 0: 0 = rising edge, 1 = falling edge, 2 = both edges.
REQ-006 Port i_CLK, input, 1: sole clock; all logic runs on its rising edge.
REQ-007 Port i_RST_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 Port i_STRB, input, 1: slow strobe or clock from a foreign domain, treated as asynchronous data.
REQ-009 Port i_DATA, input, CH*W: channel words, channel 0 in the LSBs; quasi-static around each strobe edge.
REQ-010 Port o_VALID, input/output direction output, 1: FIFO is non-empty, and o_DATA holds the oldest entry.
REQ-011 Port i_READY, input, 1: consumer accepts o_DATA in any cycle where o_VALID and i_READY are both high.
REQ-012 Port o_DATA, output, CH*W: head entry of the FIFO.
REQ-013 Port o_LEVEL, output, $clog2(DEPTH)+1: current FIFO occupancy.
REQ-014 Port o_OVF, output, 1: sticky overflow flag.
REQ-015 Port i_OVF_CLR, input, 1: synchronous clear of o_OVF.

Function
REQ-016 i_STRB SHALL pass through a 2-flop synchroniser, then into a 2*STABLE-bit history shift register.
REQ-017 A rising qualify SHALL assert for one cycle when the history equals STABLE zeros (older) followed by STABLE ones (newer).
- For STABLE=3 the history pattern is 000111.
REQ-018 A falling qualify SHALL assert for one cycle on the mirrored pattern (STABLE ones followed by STABLE zeros).
- EDGE selects which qualify types push.
- EDGE=2 pushes on either type.
REQ-019 After a qualify, the history SHALL be left to shift normally; the pattern cannot recur without a new edge, so one edge yields exactly one push.
REQ-020 Glitches shorter than STABLE cycles (synchronised) SHALL produce no push.
REQ-021 On a push cycle, i_DATA sampled in that same cycle SHALL be written to the tail entry.
- Latency from i_STRB edge to push: 2 + STABLE cycles.
REQ-022 o_VALID and o_DATA SHALL reflect a push written into an empty FIFO on the next cycle (show-ahead).
REQ-023 A pop SHALL occur when o_VALID && i_READY.
- o_DATA SHALL advance to the next entry in the following cycle.
- o_VALID SHALL deassert if the FIFO becomes empty.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 o_LEVEL SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-026 Push when full with no pop: data SHALL be dropped, FIFO unchanged, o_OVF set to 1 next cycle.
REQ-027 Push when full with a pop in the same cycle: both SHALL be accepted, o_LEVEL stays DEPTH, and no overflow is flagged.
REQ-028 Pop when empty SHALL be ignored; o_LEVEL never underflows.
REQ-029 i_OVF_CLR together with a new overflow in the same cycle: set SHALL win, and o_OVF stays 1.
REQ-030 o_DATA content while o_VALID=0 is don't-care, but SHALL be deterministic (last head value or reset value).

Reset
REQ-031 While i_RST_n=0, the following SHALL be forced:
- synchroniser, history and pointers to 0
- o_LEVEL = 0, o_VALID = 0, o_OVF = 0, o_DATA = 0
REQ-032 Reset asserted mid-operation SHALL discard all FIFO content immediately (asynchronous).
REQ-033 Because history restarts at 0 after reset, a strobe already high at reset release SHALL yield a rising push after 2+STABLE cycles when EDGE is 0 or 2.
- EDGE=1 with a low strobe after reset SHALL yield no push until a genuine falling edge occurs.
REQ-034 FIFO storage array needs no reset.

Structure
REQ-035 A shared package mmp_pkg SHALL hold EDGE encodings EDGE_RISE=0, EDGE_FALL=1 and EDGE_BOTH=2.
REQ-036 The edge synchroniser/qualifier SHALL be one sub-module, mmp_strobe_qual (parameters STABLE, EDGE; outputs a single push pulse).
REQ-037 FIFO storage and pointers SHALL stay in the top module.

Verification
REQ-038 Test 1, single rising edge: STABLE=3, EDGE=0, i_DATA=0x1234_ABCD, clean i_STRB edge.
- Response: exactly one push 5 cycles later; o_VALID=1 next cycle with o_DATA=0x1234ABCD; o_LEVEL=1.
REQ-039 Test 2, glitch rejection: 2-cycle high pulse on i_STRB.
- Response: no push, o_LEVEL stays 0.
REQ-040 Test 3, overflow: DEPTH=4, i_READY=0, 5 strobes with data 1..5.
- Response: o_LEVEL=4, o_OVF=1.
- Draining yields 1,2,3,4; value 5 is lost.
REQ-041 Test 4, full with simultaneous pop: FIFO full, i_READY=1 in the cycle of the 5th push.
- Response: o_LEVEL stays 4, o_OVF=0, output order is preserved.
REQ-042 Test 5, both edges: EDGE=2, one full strobe period.
- Response: two pushes, one per edge, each capturing i_DATA as it was at that edge.
REQ-043 Test 6, reset mid-stream: assert i_RST_n=0 with o_LEVEL=3.
- Response: o_VALID=0, o_LEVEL=0, o_OVF=0 immediately, without waiting for i_CLK.
- Clear-vs-set priority: i_OVF_CLR=1 and an overflow in the same cycle leaves o_OVF=1.
